// File: rtl/tournament_predictor.sv
// tournament_predictor: tournament branch predictor combining a local-history
// predictor, a global-history predictor and a choice predictor.
// Tables are cleared by an internal sweep after reset. Predictions are
// registered and appear one cycle after the request.
// Optional performance counters are enabled by defining TP_PERF_CNT_EN.

module tournament_predictor #(
   parameter int PC_WIDTH         = 12,
   parameter int LHT_IDX_BITS     = 10,
   parameter int LOCAL_HIST_BITS  = 10,
   parameter int GLOBAL_HIST_BITS = 12,
   parameter int LOCAL_CTR_BITS   = 3,
   parameter int GLOBAL_CTR_BITS  = 2,
   parameter int CHOICE_CTR_BITS  = 2
) (
   input  logic                clock,
   input  logic                reset,
   output logic                ready,
   input  logic                predict_valid,
   input  logic [PC_WIDTH-1:0] predict_pc,
   output logic                pred_valid,
   output logic                pred_taken,
   output logic                pred_choice,
   input  logic                update_valid,
   input  logic [PC_WIDTH-1:0] update_pc,
   input  logic                update_taken
`ifdef TP_PERF_CNT_EN
   ,
   output logic [31:0]         perf_updates,
   output logic [31:0]         perf_mispredicts
`endif
);

   localparam int LHT_DEPTH  = 1 << LHT_IDX_BITS;
   localparam int LCTR_DEPTH = 1 << LOCAL_HIST_BITS;
   localparam int G_DEPTH    = 1 << GLOBAL_HIST_BITS;
   localparam int IDX_W =
      (LHT_IDX_BITS > LOCAL_HIST_BITS)
         ? ((LHT_IDX_BITS > GLOBAL_HIST_BITS) ? LHT_IDX_BITS : GLOBAL_HIST_BITS)
         : ((LOCAL_HIST_BITS > GLOBAL_HIST_BITS) ? LOCAL_HIST_BITS : GLOBAL_HIST_BITS);

   // Weakly not-taken / weakly local starting point: 2^(n-1)-1
   localparam logic [LOCAL_CTR_BITS-1:0]  LCTR_INIT = LOCAL_CTR_BITS'((1 << (LOCAL_CTR_BITS - 1)) - 1);
   localparam logic [GLOBAL_CTR_BITS-1:0] GCTR_INIT = GLOBAL_CTR_BITS'((1 << (GLOBAL_CTR_BITS - 1)) - 1);
   localparam logic [CHOICE_CTR_BITS-1:0] CCTR_INIT = CHOICE_CTR_BITS'((1 << (CHOICE_CTR_BITS - 1)) - 1);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t                      state, state_next;
   logic [IDX_W-1:0]            idx;

   logic [LOCAL_HIST_BITS-1:0]  lht  [LHT_DEPTH];
   logic [LOCAL_CTR_BITS-1:0]   lctr [LCTR_DEPTH];
   logic [GLOBAL_CTR_BITS-1:0]  gctr [G_DEPTH];
   logic [CHOICE_CTR_BITS-1:0]  cctr [G_DEPTH];
   logic [GLOBAL_HIST_BITS-1:0] ghr;

   logic sweeping, upd, acc;
   logic init_lht, init_lctr, init_g;

   logic [LOCAL_HIST_BITS-1:0]  p_lh;
   logic                        p_lp, p_gp, p_c, p_taken;

   logic [LHT_IDX_BITS-1:0]     u_idx;
   logic [LOCAL_HIST_BITS-1:0]  u_lh, u_lh_next;
   logic [LOCAL_CTR_BITS-1:0]   u_lctr, u_lctr_next;
   logic [GLOBAL_CTR_BITS-1:0]  u_gctr, u_gctr_next;
   logic [CHOICE_CTR_BITS-1:0]  u_cctr, u_cctr_next;
   logic [GLOBAL_HIST_BITS-1:0] ghr_next;
   logic                        u_lp, u_gp;

   // PC bits above the LHT index are intentionally ignored (aliasing allowed)
   logic unused_pc_bits;
   assign unused_pc_bits = ^{predict_pc, update_pc};

   // Sweep/run qualifiers; a table is only swept while idx is inside its depth
   always_comb begin
      sweeping  = (state == S_INIT) && !reset;
      upd       = (state == S_RUN) && !reset && update_valid;
      acc       = (state == S_RUN) && !reset && predict_valid;
      init_lht  = sweeping && ((idx >> LHT_IDX_BITS) == '0);
      init_lctr = sweeping && ((idx >> LOCAL_HIST_BITS) == '0);
      init_g    = sweeping && ((idx >> GLOBAL_HIST_BITS) == '0);
   end

   // State register and sweep index
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_INIT;
         idx   <= '0;
      end else begin
         state <= state_next;
         if (state == S_INIT)
            idx <= idx + 1'b1;
      end
   end

   // Next-state and ready: leave INIT after the last sweep entry is written
   always_comb begin
      state_next = state;
      ready      = 1'b0;
      case (state)
         S_INIT: if (idx == '1) state_next = S_RUN;
         S_RUN:  ready = 1'b1;
         default: state_next = S_INIT;
      endcase
   end

   // Prediction lookup from pre-update table contents
   always_comb begin
      p_lh    = lht[predict_pc[LHT_IDX_BITS-1:0]];
      p_lp    = lctr[p_lh][LOCAL_CTR_BITS-1];
      p_gp    = gctr[ghr][GLOBAL_CTR_BITS-1];
      p_c     = cctr[ghr][CHOICE_CTR_BITS-1];
      p_taken = p_c ? p_gp : p_lp;
   end

   // Update recomputation and saturating next values
   always_comb begin
      u_idx       = update_pc[LHT_IDX_BITS-1:0];
      u_lh        = lht[u_idx];
      u_lctr      = lctr[u_lh];
      u_gctr      = gctr[ghr];
      u_cctr      = cctr[ghr];
      u_lp        = u_lctr[LOCAL_CTR_BITS-1];
      u_gp        = u_gctr[GLOBAL_CTR_BITS-1];
      u_lctr_next = u_lctr;
      u_gctr_next = u_gctr;
      u_cctr_next = u_cctr;
      if (update_taken) begin
         if (u_lctr != '1) u_lctr_next = u_lctr + 1'b1;
         if (u_gctr != '1) u_gctr_next = u_gctr + 1'b1;
      end else begin
         if (u_lctr != '0) u_lctr_next = u_lctr - 1'b1;
         if (u_gctr != '0) u_gctr_next = u_gctr - 1'b1;
      end
      if (u_lp != u_gp) begin
         if (u_gp == update_taken) begin
            if (u_cctr != '1) u_cctr_next = u_cctr + 1'b1;
         end else begin
            if (u_cctr != '0) u_cctr_next = u_cctr - 1'b1;
         end
      end
      u_lh_next = LOCAL_HIST_BITS'({u_lh, update_taken});
      ghr_next  = GLOBAL_HIST_BITS'({ghr, update_taken});
   end

   // Local history table: sweep clear or history shift on update
   always_ff @(posedge clock) begin
      if (init_lht)
         lht[idx[LHT_IDX_BITS-1:0]] <= '0;
      else if (upd)
         lht[u_idx] <= u_lh_next;
   end

   // Local counter table
   always_ff @(posedge clock) begin
      if (init_lctr)
         lctr[idx[LOCAL_HIST_BITS-1:0]] <= LCTR_INIT;
      else if (upd)
         lctr[u_lh] <= u_lctr_next;
   end

   // Global counter table
   always_ff @(posedge clock) begin
      if (init_g)
         gctr[idx[GLOBAL_HIST_BITS-1:0]] <= GCTR_INIT;
      else if (upd)
         gctr[ghr] <= u_gctr_next;
   end

   // Choice counter table
   always_ff @(posedge clock) begin
      if (init_g)
         cctr[idx[GLOBAL_HIST_BITS-1:0]] <= CCTR_INIT;
      else if (upd)
         cctr[ghr] <= u_cctr_next;
   end

   // Global history register, held at zero while sweeping
   always_ff @(posedge clock) begin
      if (reset || state == S_INIT)
         ghr <= '0;
      else if (upd)
         ghr <= ghr_next;
   end

   // Registered prediction outputs; taken/choice hold when no request accepted
   always_ff @(posedge clock) begin
      if (reset) begin
         pred_valid  <= 1'b0;
         pred_taken  <= 1'b0;
         pred_choice <= 1'b0;
      end else begin
         pred_valid <= acc;
         if (acc) begin
            pred_taken  <= p_taken;
            pred_choice <= p_c;
         end
      end
   end

`ifdef TP_PERF_CNT_EN
   logic u_c, u_final;

   // Final prediction as it would have been made for the resolving branch
   always_comb begin
      u_c     = u_cctr[CHOICE_CTR_BITS-1];
      u_final = u_c ? u_gp : u_lp;
   end

   // Update and misprediction counters, free-running modulo 2^32
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_updates     <= '0;
         perf_mispredicts <= '0;
      end else if (upd) begin
         perf_updates <= perf_updates + 32'd1;
         if (u_final != update_taken)
            perf_mispredicts <= perf_mispredicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tournament_predictor.sv
// tb_tournament_predictor: directed, table-driven bench for tournament_predictor
// at default parameters (sweep length 4096). Perf counter checks are compiled
// only when TP_PERF_CNT_EN is defined.

module tb_tournament_predictor;

   localparam int D = 4096;
   localparam logic [11:0] PC_A = 12'h010;
   localparam logic [11:0] PC_B = 12'h020;
   localparam logic [11:0] PC_A_ALIAS = 12'h410;

   logic        clock = 1'b0;
   logic        reset;
   logic        ready;
   logic        predict_valid;
   logic [11:0] predict_pc;
   logic        pred_valid;
   logic        pred_taken;
   logic        pred_choice;
   logic        update_valid;
   logic [11:0] update_pc;
   logic        update_taken;
`ifdef TP_PERF_CNT_EN
   logic [31:0] perf_updates;
   logic [31:0] perf_mispredicts;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   tournament_predictor #(
      .PC_WIDTH        (12),
      .LHT_IDX_BITS    (10),
      .LOCAL_HIST_BITS (10),
      .GLOBAL_HIST_BITS(12),
      .LOCAL_CTR_BITS  (3),
      .GLOBAL_CTR_BITS (2),
      .CHOICE_CTR_BITS (2)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .ready           (ready),
      .predict_valid   (predict_valid),
      .predict_pc      (predict_pc),
      .pred_valid      (pred_valid),
      .pred_taken      (pred_taken),
      .pred_choice     (pred_choice),
      .update_valid    (update_valid),
      .update_pc       (update_pc),
      .update_taken    (update_taken)
`ifdef TP_PERF_CNT_EN
      ,
      .perf_updates    (perf_updates),
      .perf_mispredicts(perf_mispredicts)
`endif
   );

   typedef struct {
      logic        pv;
      logic [11:0] ppc;
      logic        uv;
      logic [11:0] upc;
      logic        ut;
      logic        chk;
      logic        et;
      logic        ec;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic void add(input logic pv, input logic [11:0] ppc, input logic uv,
                               input logic [11:0] upc, input logic ut, input logic chk,
                               input logic et, input logic ec);
      vec_t v;
      v.pv = pv; v.ppc = ppc; v.uv = uv; v.upc = upc; v.ut = ut;
      v.chk = chk; v.et = et; v.ec = ec;
      vq.push_back(v);
   endfunction

   // One vector per cycle; outputs sampled 1 time unit after the edge
   task automatic run_vecs(input int tag);
      for (int i = 0; i < vq.size(); i++) begin
         predict_valid = vq[i].pv;
         predict_pc    = vq[i].ppc;
         update_valid  = vq[i].uv;
         update_pc     = vq[i].upc;
         update_taken  = vq[i].ut;
         @(posedge clock);
         #1;
         check($sformatf("t%0d v%0d pred_valid", tag, i), {31'd0, pred_valid}, {31'd0, vq[i].pv});
         if (vq[i].chk) begin
            check($sformatf("t%0d v%0d pred_taken", tag, i), {31'd0, pred_taken}, {31'd0, vq[i].et});
            check($sformatf("t%0d v%0d pred_choice", tag, i), {31'd0, pred_choice}, {31'd0, vq[i].ec});
         end
      end
      predict_valid = 1'b0;
      update_valid  = 1'b0;
      vq.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock);
      #1;
   endtask

   // Release reset and require ready to rise on exactly the D-th edge
   task automatic sweep(input string tag);
      reset = 1'b0;
      for (int i = 1; i <= D; i++) begin
         @(posedge clock);
         #1;
         if (i == D - 1) check({tag, " ready before D"}, {31'd0, ready}, 32'd0);
      end
      check({tag, " ready at D"}, {31'd0, ready}, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic pv_seen;
      reset         = 1'b1;
      predict_valid = 1'b0;
      predict_pc    = '0;
      update_valid  = 1'b0;
      update_pc     = '0;
      update_taken  = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("reset ready", {31'd0, ready}, 32'd0);
      check("reset pred_valid", {31'd0, pred_valid}, 32'd0);
      check("reset pred_taken", {31'd0, pred_taken}, 32'd0);
      check("reset pred_choice", {31'd0, pred_choice}, 32'd0);
`ifdef TP_PERF_CNT_EN
      check("reset perf_updates", perf_updates, 32'd0);
      check("reset perf_mispredicts", perf_mispredicts, 32'd0);
`endif

      // First sweep with requests and updates held high: all must be ignored
      predict_valid = 1'b1;
      predict_pc    = PC_A;
      update_valid  = 1'b1;
      update_pc     = PC_A;
      update_taken  = 1'b1;
      reset         = 1'b0;
      pv_seen       = 1'b0;
      for (int i = 1; i <= D; i++) begin
         @(posedge clock);
         #1;
         if (pred_valid) pv_seen = 1'b1;
         if (i == D - 1) check("sweep0 ready before D", {31'd0, ready}, 32'd0);
      end
      check("sweep0 ready at D", {31'd0, ready}, 32'd1);
      check("sweep0 pred_valid during INIT", {31'd0, pv_seen}, 32'd0);
`ifdef TP_PERF_CNT_EN
      check("sweep0 perf_updates", perf_updates, 32'd0);
`endif
      update_valid = 1'b0;
      @(posedge clock);
      #1;
      check("first predict pred_valid", {31'd0, pred_valid}, 32'd1);
      check("first predict pred_taken", {31'd0, pred_taken}, 32'd0);
      check("first predict pred_choice", {31'd0, pred_choice}, 32'd0);
      predict_valid = 1'b0;
      @(posedge clock);
      #1;
      check("idle pred_valid", {31'd0, pred_valid}, 32'd0);

      // Reset in RUN, then a reset pulse 100 cycles into the new sweep
      do_reset();
      check("run reset ready", {31'd0, ready}, 32'd0);
      reset = 1'b0;
      repeat (100) @(posedge clock);
      #1;
      check("mid sweep ready", {31'd0, ready}, 32'd0);
      do_reset();
      sweep("restart");

      // Training with a same-entry predict/update collision on update 11
      for (int i = 0; i < 10; i++) add(0, '0, 1, PC_A, 1, 0, 0, 0);
      add(1, PC_A, 1, PC_A, 1, 1, 0, 0);
      add(1, PC_A, 0, '0, 0, 1, 1, 0);
      add(0, '0, 1, PC_A, 1, 0, 0, 0);
      add(0, '0, 1, PC_A, 1, 0, 0, 0);
      add(1, PC_A_ALIAS, 0, '0, 0, 1, 1, 0);
      add(0, '0, 0, '0, 0, 1, 1, 0);
      run_vecs(2);
`ifdef TP_PERF_CNT_EN
      check("train perf_updates", perf_updates, 32'd13);
      check("train perf_mispredicts", perf_mispredicts, 32'd11);
`endif

      // Saturation: predictions must stay taken, then one not-taken update
      for (int i = 0; i < 100; i++) add(1, PC_A, 1, PC_A, 1, 1, 1, 0);
      add(0, '0, 1, PC_A, 0, 0, 0, 0);
      add(1, PC_A, 0, '0, 0, 1, 0, 0);
      run_vecs(3);
`ifdef TP_PERF_CNT_EN
      check("sat perf_updates", perf_updates, 32'd114);
      check("sat perf_mispredicts", perf_mispredicts, 32'd12);
`endif

      // Choice moves to global: global correct where local is wrong
      do_reset();
      sweep("choice");
      for (int i = 0; i < 12; i++) add(0, '0, 1, PC_A, 1, 0, 0, 0);
      add(0, '0, 1, PC_B, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) add(0, '0, 1, PC_A, 1, 0, 0, 0);
      add(1, PC_A, 0, '0, 0, 1, 0, 1);
      run_vecs(4);

      // Decrement saturation at zero
      do_reset();
      sweep("decr");
      for (int i = 0; i < 4; i++) add(0, '0, 1, PC_B, 0, 0, 0, 0);
      add(1, PC_B, 0, '0, 0, 1, 0, 0);
      run_vecs(5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
